// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel word deserializer.
// Holds the FSM state encoding and the bit-counter width helper.
// No logic here: constants and a pure function only.
package sipo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    // Bit counter must represent 0..WIDTH.
    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_word_deserializer_if.sv
// Bundle of serial-input and parallel-output signals for the deserializer.
// slave = deserializer view, master = serial source plus word consumer view.
// parity_err is present only when SIPO_PARITY_EN is defined.
interface sipo_word_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             s_in;
    logic             s_en;
    logic             s_sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    modport slave (
        input  s_in, s_en, s_sync, dout_ready,
        output dout, dout_valid, busy, overrun
`ifdef SIPO_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output s_in, s_en, s_sync, dout_ready,
        input  dout, dout_valid, busy, overrun
`ifdef SIPO_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/sipo_out_hold.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
// Latency: word_done_i loads dout_o on the same rising edge.
// Backpressure: a word completing while full and not being drained is dropped, overrun_o set.
// Ports: clk/rst, word_done_i/word_in_i from the shifter, dout_ready_i from the consumer;
//        dout_o/dout_valid_o/overrun_o to the consumer.
module sipo_out_hold #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_done_i,
    input  logic [WIDTH-1:0] word_in_i,
    input  logic             dout_ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             overrun_o
);
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             xfer;
    logic             load;

    assign xfer = valid_q & dout_ready_i;
    // A word may land whenever the register is empty or is emptied on this same edge.
    assign load = word_done_i & (~valid_q | dout_ready_i);

    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            dout_d  = word_in_i;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (word_done_i && valid_q && !dout_ready_i) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign overrun_o    = overrun_q;
endmodule

// File: rtl/sipo_word_deserializer.sv
// Serial-to-parallel word deserializer: sync-framed serial bits rebuilt into WIDTH-bit words.
// Latency: word lands in dout on the edge that samples its last bit (parity bit with SIPO_PARITY_EN).
// Backpressure: single holding register; a word completing while full is dropped and overrun set.
// Ports: clk, rst (async active-high), bus (sipo_word_deserializer_if.slave: s_in/s_en/s_sync in,
//        dout/dout_valid/dout_ready handshake, busy, overrun, parity_err with SIPO_PARITY_EN).
module sipo_word_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    sipo_word_deserializer_if.slave  bus
);
    localparam int CNT_W = sipo_cnt_w(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sh_shift, sh_first;
    logic             last_bit;
    logic             word_done;
    logic [WIDTH-1:0] word_in;

    // sh_first clears the stale bits so an abandoned word cannot leak into the next one.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_shift = {sh_q[WIDTH-2:0], bus.s_in};
            assign sh_first = {{(WIDTH-1){1'b0}}, bus.s_in};
        end else begin : g_lsb
            assign sh_shift = {bus.s_in, sh_q[WIDTH-1:1]};
            assign sh_first = {bus.s_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SIPO_PARITY_EN
    logic par_bad;
    logic word_load;
    logic parity_err_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        word_done = 1'b0;
        word_in   = sh_shift;
`ifdef SIPO_PARITY_EN
        par_bad   = 1'b0;
`endif
        if (bus.s_en) begin
            if (bus.s_sync) begin
                // Sync always starts a fresh word, silently abandoning any partial one.
                state_d = ST_SHIFT;
                cnt_d   = CNT_W'(1);
                sh_d    = sh_first;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        sh_d = sh_shift;
                        if (last_bit) begin
                            cnt_d = '0;
`ifdef SIPO_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d   = ST_IDLE;
                            word_done = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    ST_PAR: begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        state_d   = ST_IDLE;
                        word_done = 1'b1;
                        word_in   = sh_q;
                        par_bad   = ^{sh_q, bus.s_in};
                    end
`endif
                    default: begin
                        // IDLE: unframed bits are ignored.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    sipo_out_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .word_done_i  (word_done),
        .word_in_i    (word_in),
        .dout_ready_i (bus.dout_ready),
        .dout_o       (bus.dout),
        .dout_valid_o (bus.dout_valid),
        .overrun_o    (bus.overrun)
    );

`ifdef SIPO_PARITY_EN
    // Parity status follows the delivered word only; dropped words leave it untouched.
    assign word_load = word_done & (~bus.dout_valid | bus.dout_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (word_load) begin
            parity_err_q <= par_bad;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.busy = (state_q != ST_IDLE);
endmodule
